sig_align_add_norm: RTL and testbench

SIG_ALIGN_ADD_NORM -- requirements
Module: sig_align_add_norm

---
 rtl/sig_align_add_norm_if.sv | 23 ++
 rtl/sig_align_add_norm.sv | 121 ++++++++++++
 tb/tb_sig_align_add_norm.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sig_align_add_norm_if.sv
// Operand/result bundle for the significand align-add-normalize pipeline.
interface sig_align_add_norm_if;
  logic        valid_in;
  logic [23:0] sig_non_shift;
  logic [23:0] sig_shift;
  logic [7:0]  amt;
  logic [7:0]  exp_in;
  logic        valid_out;
  logic [23:0] norm_sig;
  logic [7:0]  norm_exp;
  logic        overflow;
  logic        zero;

  modport master (
    output valid_in, sig_non_shift, sig_shift, amt, exp_in,
    input  valid_out, norm_sig, norm_exp, overflow, zero
  );

  modport slave (
    input  valid_in, sig_non_shift, sig_shift, amt, exp_in,
    output valid_out, norm_sig, norm_exp, overflow, zero
  );
endinterface

// File: rtl/sig_align_add_norm.sv
// Two-stage significand align + carry-select add, then leading-zero normalize.
// Latency 2, one result per cycle, no backpressure.
module sig_align_add_norm (
  input logic               clk,
  input logic               rst,
  sig_align_add_norm_if.slave bus
);
  logic [23:0] aligned;
  logic [7:0]  sum_lo;
  logic [8:0]  c_lo;
  logic [8:0]  mid0, mid1, hi0, hi1;
  logic        c_mid;
  logic [23:0] sum_c;
  logic        cout_c;

  always_comb begin
    aligned = (bus.amt >= 8'd24) ? 24'd0 : (bus.sig_shift >> bus.amt);
  end

  // Low byte ripples; upper bytes are precomputed for both carry-ins and selected.
  always_comb begin
    c_lo    = 9'd0;
    sum_lo  = 8'd0;
    for (int i = 0; i < 8; i++) begin
      sum_lo[i]  = bus.sig_non_shift[i] ^ aligned[i] ^ c_lo[i];
      c_lo[i+1]  = (bus.sig_non_shift[i] & aligned[i]) |
                   (c_lo[i] & (bus.sig_non_shift[i] ^ aligned[i]));
    end
    mid0   = {1'b0, bus.sig_non_shift[15:8]}  + {1'b0, aligned[15:8]};
    mid1   = {1'b0, bus.sig_non_shift[15:8]}  + {1'b0, aligned[15:8]}  + 9'd1;
    hi0    = {1'b0, bus.sig_non_shift[23:16]} + {1'b0, aligned[23:16]};
    hi1    = {1'b0, bus.sig_non_shift[23:16]} + {1'b0, aligned[23:16]} + 9'd1;
    c_mid  = c_lo[8] ? mid1[8] : mid0[8];
    sum_c  = {(c_mid ? hi1[7:0] : hi0[7:0]),
              (c_lo[8] ? mid1[7:0] : mid0[7:0]),
              sum_lo};
    cout_c = c_mid ? hi1[8] : hi0[8];
  end

  logic [23:0] s1_sum;
  logic        s1_cout;
  logic [7:0]  s1_exp;
  logic        s1_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_sum  <= 24'd0;
      s1_cout <= 1'b0;
      s1_exp  <= 8'd0;
      s1_vld  <= 1'b0;
    end else begin
      s1_sum  <= sum_c;
      s1_cout <= cout_c;
      s1_exp  <= bus.exp_in;
      s1_vld  <= bus.valid_in;
    end
  end

  logic [8:0]  e_eff;
  logic [4:0]  lz;
  logic [8:0]  n_exp9;
  logic [23:0] n_sig;
  logic        n_ovf;
  logic        n_zero;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (s1_sum[i]) lz = 5'(23 - i);
    end
  end

  always_comb begin
    e_eff  = (s1_exp == 8'd0) ? 9'd1 : {1'b0, s1_exp};
    n_sig  = 24'd0;
    n_exp9 = 9'd0;
    n_ovf  = 1'b0;
    n_zero = 1'b0;
    if (s1_cout) begin
      n_sig  = {1'b1, s1_sum[23:1]};
      n_exp9 = e_eff + 9'd1;
    end else if (s1_sum[23]) begin
      n_sig  = s1_sum;
      n_exp9 = e_eff;
    end else if (s1_sum == 24'd0) begin
      n_zero = 1'b1;
    end else if ({4'd0, lz} < e_eff) begin
      n_sig  = s1_sum << lz;
      n_exp9 = e_eff - {4'd0, lz};
    end else begin
      // Exponent runs out before the hidden bit is reached: denormal result.
      n_sig  = s1_sum << (e_eff - 9'd1);
      n_exp9 = 9'd0;
    end
    if (n_exp9 >= 9'd255 || s1_exp == 8'hFF) begin
      n_sig  = 24'd0;
      n_exp9 = 9'd255;
      n_ovf  = 1'b1;
      n_zero = 1'b0;
    end
  end

  // Result registers only load on valid data so idle cycles hold the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.valid_out <= 1'b0;
      bus.norm_sig  <= 24'd0;
      bus.norm_exp  <= 8'd0;
      bus.overflow  <= 1'b0;
      bus.zero      <= 1'b0;
    end else begin
      bus.valid_out <= s1_vld;
      if (s1_vld) begin
        bus.norm_sig <= n_sig;
        bus.norm_exp <= n_exp9[7:0];
        bus.overflow <= n_ovf;
        bus.zero     <= n_zero;
      end
    end
  end
endmodule

// File: tb/tb_sig_align_add_norm.sv
// Directed-vector bench for sig_align_add_norm: streamed table plus reset corner cases.
module tb_sig_align_add_norm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sig_align_add_norm_if bus ();

  sig_align_add_norm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [23:0] non;
    logic [23:0] shf;
    logic [7:0]  amt;
    logic [7:0]  exp;
    logic [23:0] e_sig;
    logic [7:0]  e_exp;
    logic        e_ovf;
    logic        e_zero;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_idle();
    bus.valid_in      = 1'b0;
    bus.sig_non_shift = 24'd0;
    bus.sig_shift     = 24'd0;
    bus.amt           = 8'd0;
    bus.exp_in        = 8'd0;
  endtask

  task automatic drive_vec(input int k);
    bus.valid_in      = 1'b1;
    bus.sig_non_shift = vt[k].non;
    bus.sig_shift     = vt[k].shf;
    bus.amt           = vt[k].amt;
    bus.exp_in        = vt[k].exp;
  endtask

  task automatic check_vec(input int k);
    string tag;
    tag = $sformatf("v%0d", k);
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'd1);
    chk({tag, ".norm_sig"},  32'(bus.norm_sig),  32'(vt[k].e_sig));
    chk({tag, ".norm_exp"},  32'(bus.norm_exp),  32'(vt[k].e_exp));
    chk({tag, ".overflow"},  32'(bus.overflow),  32'(vt[k].e_ovf));
    chk({tag, ".zero"},      32'(bus.zero),      32'(vt[k].e_zero));
  endtask

  // Back-to-back stream: vector driven after edge n must appear right after edge n+2.
  task automatic run_stream(input int first, input int cnt);
    for (int i = 0; i < cnt + 2; i++) begin
      @(posedge clk);
      #1;
      if (i >= 2) check_vec(first + i - 2);
      if (i < cnt) drive_vec(first + i);
      else         drive_idle();
    end
    @(posedge clk);
    #1;
    chk("stream_end.valid_out", 32'(bus.valid_out), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'd0);
    chk({tag, ".norm_sig"},  32'(bus.norm_sig),  32'd0);
    chk({tag, ".norm_exp"},  32'(bus.norm_exp),  32'd0);
    chk({tag, ".overflow"},  32'(bus.overflow),  32'd0);
    chk({tag, ".zero"},      32'(bus.zero),      32'd0);
  endtask

  initial begin
    //          non        shift      amt    exp      sig        exp    ov    z
    vt[0]  = '{24'h800000, 24'h800000, 8'd0,  8'd127, 24'h800000, 8'd128, 1'b0, 1'b0};
    vt[1]  = '{24'h800000, 24'hC00000, 8'd1,  8'd127, 24'hE00000, 8'd127, 1'b0, 1'b0};
    vt[2]  = '{24'h9A0000, 24'hFFFFFF, 8'd30, 8'd100, 24'h9A0000, 8'd100, 1'b0, 1'b0};
    vt[3]  = '{24'hFFFFFF, 24'hFFFFFF, 8'd0,  8'd254, 24'h000000, 8'd255, 1'b1, 1'b0};
    vt[4]  = '{24'h400000, 24'h400000, 8'd0,  8'd0,   24'h800000, 8'd1,   1'b0, 1'b0};
    vt[5]  = '{24'h000001, 24'h000000, 8'd0,  8'd0,   24'h000001, 8'd0,   1'b0, 1'b0};
    vt[6]  = '{24'h000000, 24'h000000, 8'd0,  8'd50,  24'h000000, 8'd0,   1'b0, 1'b1};
    vt[7]  = '{24'h100000, 24'h000000, 8'd0,  8'd10,  24'h800000, 8'd7,   1'b0, 1'b0};
    vt[8]  = '{24'h010000, 24'h000000, 8'd0,  8'd5,   24'h100000, 8'd0,   1'b0, 1'b0};
    vt[9]  = '{24'h800000, 24'h000000, 8'd0,  8'd255, 24'h000000, 8'd255, 1'b1, 1'b0};
    vt[10] = '{24'h800000, 24'hFFFFFF, 8'd23, 8'd90,  24'h800001, 8'd90,  1'b0, 1'b0};
    vt[11] = '{24'h800000, 24'hFFFFFF, 8'd24, 8'd90,  24'h800000, 8'd90,  1'b0, 1'b0};
    vt[12] = '{24'h0000FF, 24'h000001, 8'd0,  8'd20,  24'h800000, 8'd5,   1'b0, 1'b0};
    vt[13] = '{24'h7FFFFF, 24'h000001, 8'd0,  8'd60,  24'h800000, 8'd60,  1'b0, 1'b0};
    vt[14] = '{24'hFFFFFF, 24'h000001, 8'd0,  8'd60,  24'h800000, 8'd61,  1'b0, 1'b0};
    vt[15] = '{24'hC00001, 24'hC00000, 8'd0,  8'd10,  24'hC00000, 8'd11,  1'b0, 1'b0};
    vt[16] = '{24'h800000, 24'h800000, 8'd0,  8'd253, 24'h800000, 8'd254, 1'b0, 1'b0};
    vt[17] = '{24'h800000, 24'h800000, 8'd0,  8'd0,   24'h800000, 8'd2,   1'b0, 1'b0};

    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_stream(0, NV);

    // Reset with data in both stages: outputs clear immediately, in-flight data dropped.
    @(posedge clk);
    #1;
    drive_vec(0);
    @(posedge clk);
    #1;
    drive_vec(15);
    @(posedge clk);
    #1;
    chk("pre_rst.valid_out", 32'(bus.valid_out), 32'd1);
    chk("pre_rst.norm_exp",  32'(bus.norm_exp),  32'd128);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    drive_idle();
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("post_rst_flush.valid_out", 32'(bus.valid_out), 32'd0);
    end

    run_stream(10, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
